// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_encoder
//  Purpose  : Program-load front end for the 16-bit processor. Takes decoded
//             instruction fields over a valid/ready handshake, validates them,
//             packs them into the 16-bit word the decoder consumes and writes
//             them to instruction memory at sequential addresses.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start              - begin a program load (IDLE only)
//             in_valid/in_ready  - field handshake
//             in_opcode..in_last - decoded instruction fields
//             imem_we/addr/wdata - memory write port, held until imem_ready
//             imem_ready         - memory accepts the write this cycle
//             busy, done         - load status; done is a one-cycle pulse
//             word_count         - words written since start
//             err_*              - sticky error flags, cleared on start
//  Revision : 1.0  initial release
// ============================================================================
module instruction_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [1:0]        in_rd,
    input  logic [1:0]        in_rs,
    input  logic [1:0]        in_rt,
    input  logic [6:0]        in_imm7,
    input  logic [5:0]        in_nzimm,
    input  logic [8:0]        in_offset,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_opcode,
    output logic              err_nzimm,
    output logic              err_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_op_q, err_op_d;
    logic                err_nz_q, err_nz_d;
    logic                err_ov_q, err_ov_d;

    logic                w_complete;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_is_i7, w_is_n6, w_is_r, w_is_b;
    logic                w_bad_op, w_bad_nz;
    logic                w_room;
    logic [15:0]         w_enc;

    // Format decode and packing of the incoming fields.
    always_comb begin
        w_is_i7 = 1'b0;
        w_is_n6 = 1'b0;
        w_is_r  = 1'b0;
        w_is_b  = 1'b0;
        w_enc   = 16'h0000;
        case (in_opcode)
            4'b0000, 4'b0001, 4'b0101: begin
                w_is_i7 = 1'b1;
                w_enc   = {in_opcode, in_rd, in_rs, 1'b0, in_imm7};
            end
            4'b0011, 4'b1000, 4'b1001: begin
                w_is_n6 = 1'b1;
                w_enc   = {in_opcode, in_rd, in_rs, 2'b00, in_nzimm};
            end
            4'b0010, 4'b0100, 4'b0110, 4'b0111: begin
                w_is_r  = 1'b1;
                w_enc   = {in_opcode, in_rd, in_rs, in_rt, 6'b000000};
            end
            4'b1010, 4'b1011: begin
                w_is_b  = 1'b1;
                w_enc   = {in_opcode, in_rs, 1'b0, in_offset};
            end
            default: begin
                w_enc   = 16'h0000;
            end
        endcase
    end

    assign w_bad_op   = !(w_is_i7 || w_is_n6 || w_is_r || w_is_b);
    assign w_bad_nz   = w_is_n6 && (in_nzimm == 6'd0);
    assign w_complete = we_q && imem_ready;
    assign w_in_ready = (state_q == ST_LOAD) && (!we_q || imem_ready);
    assign w_accept   = in_valid && w_in_ready;

    // A word still held on the write port counts against DEPTH, even when it
    // completes on this same edge: it becomes a written word either way.
    assign w_room = ((count_q + (ADDR_W + 1)'(we_q)) < c_depth);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q && !imem_ready;
        addr_d   = addr_q + ADDR_W'(w_complete);
        count_d  = count_q + (ADDR_W + 1)'(w_complete);
        wdata_d  = wdata_q;
        err_op_d = err_op_q;
        err_nz_d = err_nz_q;
        err_ov_d = err_ov_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    count_d  = '0;
                    addr_d   = c_base_addr;
                    err_op_d = 1'b0;
                    err_nz_d = 1'b0;
                    err_ov_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_bad_op) begin
                        err_op_d = 1'b1;
                    end else if (w_bad_nz) begin
                        err_nz_d = 1'b1;
                    end else if (w_room) begin
                        // Replaces any word completing on this edge.
                        wdata_d = w_enc;
                        we_d    = 1'b1;
                    end else begin
                        err_ov_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!we_q || w_complete) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= c_base_addr;
            wdata_q  <= 16'h0000;
            count_q  <= '0;
            err_op_q <= 1'b0;
            err_nz_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            err_op_q <= err_op_d;
            err_nz_q <= err_nz_d;
            err_ov_q <= err_ov_d;
        end
    end

    assign in_ready     = w_in_ready;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign word_count   = count_q;
    assign err_opcode   = err_op_q;
    assign err_nzimm    = err_nz_q;
    assign err_overflow = err_ov_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_encoder
//  Purpose  : Self-checking bench for instruction_encoder. Expected memory
//             writes are queued as each word is offered and compared as the
//             encoder completes writes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_encoder;

    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [1:0]        in_rd, in_rs, in_rt;
    logic [6:0]        in_imm7;
    logic [5:0]        in_nzimm;
    logic [8:0]        in_offset;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              imem_ready;
    logic              busy, done;
    logic [ADDR_W:0]   word_count;
    logic              err_opcode, err_nzimm, err_overflow;

    instruction_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_rd        (in_rd),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_imm7      (in_imm7),
        .in_nzimm     (in_nzimm),
        .in_offset    (in_offset),
        .in_last      (in_last),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .imem_ready   (imem_ready),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count),
        .err_opcode   (err_opcode),
        .err_nzimm    (err_nzimm),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int load_idx;
    logic [ADDR_W+15:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc_model(input logic [3:0] op, input logic [1:0] rd,
                                              input logic [1:0] rs, input logic [1:0] rt,
                                              input logic [6:0] i7, input logic [5:0] nz,
                                              input logic [8:0] off);
        logic [15:0] w;
        w = 16'h0;
        w[15:12] = op;
        if (op == 4'hA || op == 4'hB) begin
            w[11:10] = rs;
            w[8:0]   = off;
        end else begin
            w[11:10] = rd;
            w[9:8]   = rs;
            if (op == 4'h0 || op == 4'h1 || op == 4'h5) w[6:0] = i7;
            else if (op == 4'h3 || op == 4'h8 || op == 4'h9) w[5:0] = nz;
            else w[7:6] = rt;
        end
        return w;
    endfunction

    // Write monitor: compares completed writes against the queue and checks
    // the write port holds steady while stalled.
    logic              hold_valid = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [15:0]       hold_data;
    logic              b2b_mode = 1'b0;
    logic              have_last = 1'b0;
    int                last_wr = 0;

    always @(negedge clk) begin
        logic [ADDR_W+15:0] e;
        if (!rst) begin
            if (hold_valid) begin
                check("hold_addr", 32'(imem_addr), 32'(hold_addr));
                check("hold_data", 32'(imem_wdata), 32'(hold_data));
            end
            hold_valid = imem_we && !imem_ready;
            hold_addr  = imem_addr;
            hold_data  = imem_wdata;
            if (imem_we && imem_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 32'(imem_wdata), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e[ADDR_W+15:16]));
                    check("wr_data", 32'(imem_wdata), 32'(e[15:0]));
                    if (b2b_mode && have_last) check("b2b_gap", 32'(cyc - last_wr), 32'd1);
                    last_wr   = cyc;
                    have_last = 1'b1;
                end
            end
        end else begin
            hold_valid = 1'b0;
        end
    end

    // Offer one word; returns at #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [6:0] i7, input logic [5:0] nz,
                        input logic [8:0] off, input logic last);
        int k;
        logic good;
        in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_imm7 = i7; in_nzimm = nz; in_offset = off; in_last = last;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        good = (op < 4'hC) && !((op == 4'h3 || op == 4'h8 || op == 4'h9) && nz == 6'd0);
        if (good) begin
            if (load_idx < DEPTH)
                sb.push_back({ADDR_W'(BASE_ADDR + load_idx), enc_model(op, rd, rs, rt, i7, nz, off)});
            load_idx++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        load_idx = 0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_count", 32'(word_count), 32'd0);
    endtask

    task automatic wait_done(input int exp_count);
        int k;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_count", 32'(word_count), 32'(exp_count));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = 4'h0; in_rd = 2'd0; in_rs = 2'd0; in_rt = 2'd0;
        in_imm7 = 7'd0; in_nzimm = 6'd0; in_offset = 9'd0; imem_ready = 1'b1;
        load_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_errs", 32'({err_opcode, err_nzimm, err_overflow}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single R-type word, latency and done timing.
        do_start();
        send(4'h2, 2'd1, 2'd2, 2'd3, 7'd0, 6'd0, 9'd0, 1'b1);
        check("t1_we", 32'(imem_we), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check("t1_wdata", 32'(imem_wdata), 32'h26C0);
        check("t1_in_ready_drain", 32'(in_ready), 32'd0);
        check("t1_done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("t1_done", 32'(done), 32'd1);
        check("t1_count", 32'(word_count), 32'd1);
        @(posedge clk);
        #1;
        check("t1_done_clear", 32'(done), 32'd0);

        // Back-to-back, all four formats; start mid-load must be ignored.
        b2b_mode = 1'b1; have_last = 1'b0;
        do_start();
        send(4'h0, 2'd2, 2'd1, 2'd0, 7'h7F, 6'd0, 9'd0, 1'b0);
        send(4'h3, 2'd3, 2'd0, 2'd0, 7'd0, 6'd5, 9'd0, 1'b0);
        start = 1'b1;
        send(4'hA, 2'd0, 2'd1, 2'd0, 7'd0, 6'd0, 9'h1FF, 1'b0);
        start = 1'b0;
        send(4'h2, 2'd1, 2'd2, 2'd3, 7'd0, 6'd0, 9'd0, 1'b1);
        wait_done(4);
        b2b_mode = 1'b0;

        // Memory stall during the second write.
        do_start();
        send(4'h1, 2'd0, 2'd3, 2'd0, 7'h15, 6'd0, 9'd0, 1'b0);
        send(4'h9, 2'd2, 2'd2, 2'd0, 7'd0, 6'h3F, 9'd0, 1'b0);
        imem_ready = 1'b0;
        fork
            send(4'h7, 2'd3, 2'd1, 2'd2, 7'd0, 6'd0, 9'd0, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                imem_ready = 1'b1;
            end
        join
        send(4'hB, 2'd0, 2'd2, 2'd0, 7'd0, 6'd0, 9'h0A5, 1'b1);
        wait_done(4);

        // Error words are consumed but not written; flags clear on restart.
        do_start();
        send(4'hD, 2'd1, 2'd1, 2'd1, 7'h01, 6'd1, 9'd1, 1'b0);
        send(4'h8, 2'd1, 2'd2, 2'd0, 7'd0, 6'd0, 9'd0, 1'b0);
        send(4'h5, 2'd3, 2'd3, 2'd0, 7'h2A, 6'd0, 9'd0, 1'b1);
        wait_done(1);
        check("err_flags", 32'({err_opcode, err_nzimm, err_overflow}), 32'b110);
        do_start();
        check("err_cleared", 32'({err_opcode, err_nzimm, err_overflow}), 32'd0);
        send(4'hF, 2'd0, 2'd0, 2'd0, 7'd0, 6'd0, 9'd0, 1'b1);
        check("inv_last_drain", 32'({busy, done}), 32'b10);
        @(posedge clk);
        #1;
        check("inv_last_done", 32'(done), 32'd1);
        check("inv_last_count", 32'(word_count), 32'd0);
        check("inv_last_err", 32'(err_opcode), 32'd1);
        @(posedge clk);
        #1;

        // Overflow: five valid words with DEPTH=4.
        do_start();
        for (int i = 0; i < 5; i++)
            send(4'h0, 2'(i), 2'(i + 1), 2'd0, 7'(i * 9 + 3), 6'd0, 9'd0, (i == 4));
        wait_done(4);
        check("ovf_flag", 32'({err_opcode, err_nzimm, err_overflow}), 32'b001);

        // Reset while a write is held off.
        do_start();
        imem_ready = 1'b0;
        send(4'h4, 2'd1, 2'd0, 2'd2, 7'd0, 6'd0, 9'd0, 1'b0);
        check("pre_rst_we", 32'(imem_we), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check("mid_rst_wdata", 32'(imem_wdata), 32'd0);
        check("mid_rst_state", 32'({in_ready, busy, done}), 32'd0);
        check("mid_rst_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        sb.delete();
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        send(4'h6, 2'd2, 2'd3, 2'd1, 7'd0, 6'd0, 9'd0, 1'b1);
        wait_done(1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Program-load block for the 16-bit processor; it is the encoder counterpart of the instruction decoder.
- Accepts decoded instruction fields (opcode, registers, immediates) one at a time over a valid/ready handshake.
- Validates each instruction, packs it into the 16-bit instruction word that the decoder consumes, and writes it into instruction memory at sequential addresses.
- Sits between the bench/host loader and the instruction memory write port.

Parameters:
ADDR_W, 8, instruction memory address width
BASE_ADDR, 0, first address written after start
DEPTH, 256, maximum words per program load; BASE_ADDR+DEPTH <= 2^ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a program load (honoured only in IDLE)
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder accepts fields this cycle
in_opcode  in  4  opcode
in_rd  in  2  destination register (data register for 0001)
in_rs  in  2  source/base register
in_rt  in  2  second source register (R-type only)
in_imm7  in  7  immediate for 0000/0001/0101
in_nzimm  in  6  non-zero immediate for 0011/1000/1001
in_offset  in  9  branch offset for 1010/1011
in_last  in  1  this is the final instruction of the program
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  16  encoded instruction word
imem_ready  in  1  memory accepts write this cycle
busy  out  1  high in LOAD or DRAIN
done  out  1  one-cycle pulse when the load completes
word_count  out  ADDR_W+1  words written since start
err_opcode  out  1  sticky; undefined opcode seen
err_nzimm  out  1  sticky; nzimm==0 on an N-type opcode
err_overflow  out  1  sticky; valid word dropped because DEPTH was reached

Behaviour:
Encoding. In every format, [15:12] is the opcode.
- I7 (0000, 0001, 0101): [11:10]=rd, [9:8]=rs, [7]=0, [6:0]=imm7.
- N6 (0011, 1000, 1001): [11:10]=rd, [9:8]=rs, [7:6]=00, [5:0]=nzimm.
- R (0010, 0100, 0110, 0111): [11:10]=rd, [9:8]=rs, [7:6]=rt, [5:0]=0.
- B (1010, 1011): [11:10]=rs, [9]=0, [8:0]=offset.
- Unused input fields are ignored.

Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, word_count=0, all err_*=0, state=IDLE.

State machine:
- IDLE: in_ready=0.
  - start → clear word_count and err_*, imem_addr=BASE_ADDR, go to LOAD.
- LOAD: in_ready = !imem_we || imem_ready.
  - Accept when in_valid && in_ready.
  - Accepted word that is valid and word_count<DEPTH: registered into imem_wdata; imem_we=1 on the next cycle (latency 1).
  - Invalid opcode (1100–1111) or N6 with nzimm==0: word consumed, not written, matching sticky error set.
  - Valid word with word_count==DEPTH (counting words pending write): dropped, err_overflow set.
  - Accepted with in_last → DRAIN.
- DRAIN: in_ready=0. When no write is pending (imem_we==0, or imem_we&&imem_ready this cycle) → DONE.
- DONE: done=1 for exactly one cycle → IDLE.

Write handshake:
- imem_we, imem_addr and imem_wdata stay stable until imem_ready is sampled high.
- On each completed write (imem_we && imem_ready): imem_addr+1 and word_count+1.
- Back-to-back: when imem_ready=1 every cycle and in_valid=1, one word is written per cycle.
- Simultaneous complete-and-accept: the new word replaces the old one in the same edge, and imem_we stays 1.

Boundary conditions:
- Final word invalid: nothing is written; DONE follows one cycle after DRAIN is entered.
- start outside IDLE: ignored.
- in_last on a dropped or invalid word: still ends the load.
- rst at any point, including mid-write: returns to reset values at the next edge. A held imem_we drops without the write completing.

Test Plan:
- start; R word op=0010 rd=1 rs=2 rt=3 with last, imem_ready=1 → imem_we one cycle after accept, addr 0x00, wdata 0x26C0; done 2 cycles later; word_count=1.
- Four back-to-back words: I7 op=0000 rd=2 rs=1 imm7=0x7F (0x097F), N6 op=0011 rd=3 rs=0 nzimm=5 (0x3C05), B op=1010 rs=1 offset=0x1FF (0xA5FF), then R 0x26C0 with last → written at addrs 0–3 on consecutive cycles; word_count=4.
- imem_ready held low 3 cycles during the second write → in_ready=0, addr/wdata stable, no word lost, addrs still contiguous.
- op=1101, then op=1000 with nzimm=0, then a valid word → err_opcode=1, err_nzimm=1; only the valid word is written, at addr 0; errors clear on the next start.
- DEPTH=4, feed 5 valid words (last on the 5th) → addrs 0–3 written, err_overflow=1, done pulses, word_count=4.
- rst asserted while imem_we=1 and imem_ready=0 → next cycle all outputs at reset values, state IDLE; a following start loads again from BASE_ADDR.
